// File: rtl/audio_frame_capture.sv
// EOC-strobed ADC capture into a ring buffer, assembling hop-spaced frames
// for a downstream engine with start/done handshake and overrun reporting.
module audio_frame_capture #(
   parameter int DATA_WIDTH   = 8,
   parameter int FRAME_SIZE   = 64,
   parameter int HOP_SIZE     = 64,
   parameter int RESULT_WIDTH = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [DATA_WIDTH-1:0]            din,
   input  logic                             eoc,
   output logic [FRAME_SIZE*DATA_WIDTH-1:0] frame_data,
   output logic                             proc_start,
   input  logic                             proc_done,
   input  logic [RESULT_WIDTH-1:0]          proc_result,
   output logic [RESULT_WIDTH-1:0]          result,
   output logic                             result_valid,
   output logic                             busy,
   output logic                             overrun
);

   localparam int DEPTH = 2 * FRAME_SIZE;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(FRAME_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE,
      COPY,
      START,
      WAIT_DONE
   } state_t;

   state_t state, state_nxt;

   logic                  eoc_s1, eoc_s2, eoc_d;
   logic                  wr_en;
   logic [AW-1:0]         wr_ptr, wr_ptr_nxt;
   logic [CW-1:0]         fill_cnt, fill_inc;
   logic [CW-1:0]         hop_cnt, hop_inc;
   logic                  trigger;
   logic [AW:0]           wp_ext, base_ext;
   logic [AW-1:0]         base_calc, base_q;
   logic [CW-1:0]         idx;
   logic [AW:0]           rd_sum;
   logic [AW-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] ring [DEPTH];

   assign wr_en = eoc_s2 & ~eoc_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eoc_s1 <= 1'b0;
         eoc_s2 <= 1'b0;
         eoc_d  <= 1'b0;
      end else begin
         eoc_s1 <= eoc;
         eoc_s2 <= eoc_s1;
         eoc_d  <= eoc_s2;
      end
   end

   // Ring storage: independent write port and registered read port
   always_ff @(posedge clk) begin
      if (wr_en)
         ring[wr_ptr] <= din;
      rd_data <= ring[rd_addr];
   end

   always_comb begin
      wr_ptr_nxt = wr_ptr + 1'b1;
      if (wr_ptr == AW'(DEPTH - 1))
         wr_ptr_nxt = '0;
      fill_inc = fill_cnt + 1'b1;
      if (fill_cnt == CW'(FRAME_SIZE))
         fill_inc = fill_cnt;
      hop_inc = hop_cnt + 1'b1;
      if (hop_cnt == CW'(HOP_SIZE))
         hop_inc = hop_cnt;
   end

   assign trigger = wr_en
                  && (fill_inc == CW'(FRAME_SIZE))
                  && (hop_inc == CW'(HOP_SIZE));

   // Oldest sample of the frame ending with the triggering write
   assign wp_ext = {1'b0, wr_ptr_nxt};

   always_comb begin
      base_ext = wp_ext + (AW + 1)'(DEPTH - FRAME_SIZE);
      if (wp_ext >= (AW + 1)'(FRAME_SIZE))
         base_ext = wp_ext - (AW + 1)'(FRAME_SIZE);
   end

   assign base_calc = base_ext[AW-1:0];

   always_comb begin
      rd_sum = {1'b0, base_q} + (AW + 1)'(idx);
      if (rd_sum >= (AW + 1)'(DEPTH))
         rd_sum = rd_sum - (AW + 1)'(DEPTH);
   end

   assign rd_addr = rd_sum[AW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
         hop_cnt  <= '0;
         overrun  <= 1'b0;
      end else if (wr_en) begin
         wr_ptr   <= wr_ptr_nxt;
         fill_cnt <= fill_inc;
         hop_cnt  <= trigger ? '0 : hop_inc;
         if (trigger && state != IDLE)
            overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (trigger)
               state_nxt = COPY;
         end
         COPY: begin
            if (idx == CW'(FRAME_SIZE))
               state_nxt = START;
         end
         START: begin
            state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (proc_done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Read issued at idx lands one cycle later in slot idx-1
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q       <= '0;
         idx          <= '0;
         frame_data   <= '0;
         proc_start   <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         proc_start   <= (state == START);
         result_valid <= 1'b0;
         if (state == IDLE && trigger) begin
            base_q <= base_calc;
            idx    <= '0;
         end
         if (state == COPY) begin
            idx <= idx + 1'b1;
            if (idx != '0)
               frame_data[(int'(idx) - 1) * DATA_WIDTH +: DATA_WIDTH] <= rd_data;
         end
         if (state == WAIT_DONE && proc_done) begin
            result       <= proc_result;
            result_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture: one instance with HOP=8
// (back-to-back frames) and one with HOP=4 (overlapping frames).
module tb_audio_frame_capture;

   localparam int DW = 8;
   localparam int FS = 8;
   localparam int FW = FS * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] din = '0;
   logic          eoc = 1'b0;
   logic [7:0]    proc_result = '0;

   logic [FW-1:0] frame_a, frame_b;
   logic          start_a, start_b;
   logic          done_a = 1'b0, done_b = 1'b0;
   logic [7:0]    result_a, result_b;
   logic          rv_a, rv_b, busy_a, busy_b, ovr_a, ovr_b;

   int tests = 0;
   int fails = 0;
   int start_cnt_a = 0;
   int start_cnt_b = 0;
   int rv_cnt_a = 0;

   always #5 clk = ~clk;

   audio_frame_capture #(
      .DATA_WIDTH(DW), .FRAME_SIZE(FS), .HOP_SIZE(8), .RESULT_WIDTH(8)
   ) u_hop8 (
      .clk(clk), .reset(reset), .din(din), .eoc(eoc),
      .frame_data(frame_a), .proc_start(start_a),
      .proc_done(done_a), .proc_result(proc_result),
      .result(result_a), .result_valid(rv_a),
      .busy(busy_a), .overrun(ovr_a)
   );

   audio_frame_capture #(
      .DATA_WIDTH(DW), .FRAME_SIZE(FS), .HOP_SIZE(4), .RESULT_WIDTH(8)
   ) u_hop4 (
      .clk(clk), .reset(reset), .din(din), .eoc(eoc),
      .frame_data(frame_b), .proc_start(start_b),
      .proc_done(done_b), .proc_result(proc_result),
      .result(result_b), .result_valid(rv_b),
      .busy(busy_b), .overrun(ovr_b)
   );

   always @(negedge clk) begin
      if (start_a) start_cnt_a++;
      if (start_b) start_cnt_b++;
      if (rv_a) rv_cnt_a++;
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      eoc   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] v);
      din = v;
      eoc = 1'b1;
      repeat (5) @(negedge clk);
      eoc = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_start_a(output bit got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (start_a) got = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic wait_start_b(output bit got);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (start_b) got = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic pulse_done_a(input logic [7:0] v);
      proc_result = v;
      done_a = 1'b1;
      @(negedge clk);
      done_a = 1'b0;
   endtask

   task automatic pulse_done_b(input logic [7:0] v);
      proc_result = v;
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({start_a, rv_a, busy_a, ovr_a} !== 4'b0) begin
         fails++;
         $display("FAIL reset_flags got=%b want=0000",
                  {start_a, rv_a, busy_a, ovr_a});
      end
      tests++;
      if (frame_a !== '0 || result_a !== 8'd0) begin
         fails++;
         $display("FAIL reset_data frame=%h result=%h want 0", frame_a, result_a);
      end
   endtask

   task automatic test_single();
      bit got;
      int s0, r0;
      do_reset();
      s0 = start_cnt_a;
      r0 = rv_cnt_a;
      for (int k = 1; k <= 8; k++) send(8'(k));
      wait_start_a(got);
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL single_start got=timeout want=proc_start");
      end
      tests++;
      if (frame_a !== 64'h0807060504030201) begin
         fails++;
         $display("FAIL single_frame got=%h want=0807060504030201", frame_a);
      end
      @(negedge clk);
      pulse_done_a(8'd23);
      tests++;
      if (rv_a !== 1'b1 || result_a !== 8'd23) begin
         fails++;
         $display("FAIL single_result rv=%b result=%0d want rv=1 result=23",
                  rv_a, result_a);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (rv_cnt_a - r0 != 1 || start_cnt_a - s0 != 1 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL single_pulses rv=%0d start=%0d busy=%b want 1 1 0",
                  rv_cnt_a - r0, start_cnt_a - s0, busy_a);
      end
   endtask

   task automatic test_overlap();
      bit got;
      int s0;
      logic [FW-1:0] exp [3];
      exp[0] = 64'h0807060504030201;
      exp[1] = 64'h0c0b0a0908070605;
      exp[2] = 64'h100f0e0d0c0b0a09;
      do_reset();
      s0 = start_cnt_b;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < (f == 0 ? 8 : 4); k++)
            send(8'(f == 0 ? k + 1 : 5 + 4 * f + k));
         wait_start_b(got);
         tests++;
         if (!got || frame_b !== exp[f]) begin
            fails++;
            $display("FAIL overlap_frame%0d got=%h start=%b want=%h",
                     f, frame_b, got, exp[f]);
         end
         @(negedge clk);
         pulse_done_b(8'(f));
      end
      repeat (4) @(negedge clk);
      tests++;
      if (start_cnt_b - s0 != 3 || ovr_b !== 1'b0) begin
         fails++;
         $display("FAIL overlap_count starts=%0d ovr=%b want 3 0",
                  start_cnt_b - s0, ovr_b);
      end
   endtask

   task automatic test_overrun();
      bit got;
      int s0;
      do_reset();
      s0 = start_cnt_a;
      for (int k = 1; k <= 8; k++) send(8'(k));
      wait_start_a(got);
      for (int k = 9; k <= 24; k++) send(8'(k));
      tests++;
      if (ovr_a !== 1'b1 || busy_a !== 1'b1) begin
         fails++;
         $display("FAIL overrun_flag ovr=%b busy=%b want 1 1", ovr_a, busy_a);
      end
      tests++;
      if (start_cnt_a - s0 != 1) begin
         fails++;
         $display("FAIL overrun_starts got=%0d want=1", start_cnt_a - s0);
      end
      pulse_done_a(8'h44);
      repeat (2) @(negedge clk);
      tests++;
      if (busy_a !== 1'b0 || ovr_a !== 1'b1 || result_a !== 8'h44) begin
         fails++;
         $display("FAIL overrun_release busy=%b ovr=%b result=%h want 0 1 44",
                  busy_a, ovr_a, result_a);
      end
   endtask

   task automatic test_held_eoc();
      bit got;
      int s0;
      do_reset();
      s0 = start_cnt_a;
      din = 8'hAA;
      eoc = 1'b1;
      repeat (20) @(negedge clk);
      eoc = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 2; k <= 7; k++) send(8'(k));
      repeat (30) @(negedge clk);
      tests++;
      if (start_cnt_a != s0 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL held_no_trigger starts=%0d busy=%b want 0 0",
                  start_cnt_a - s0, busy_a);
      end
      send(8'd8);
      wait_start_a(got);
      tests++;
      if (!got || frame_a !== 64'h08070605040302AA) begin
         fails++;
         $display("FAIL held_frame got=%h start=%b want=08070605040302aa",
                  frame_a, got);
      end
   endtask

   task automatic test_reset_mid();
      bit got;
      int s0;
      do_reset();
      for (int k = 1; k <= 8; k++) send(8'(k));
      wait_start_a(got);
      @(negedge clk);
      pulse_done_a(8'h5A);
      for (int k = 9; k <= 15; k++) send(8'(k));
      din = 8'd16;
      eoc = 1'b1;
      for (int i = 0; i < 20 && !busy_a; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      tests++;
      if ({start_a, busy_a, rv_a, ovr_a} !== 4'b0 || frame_a !== '0
          || result_a !== 8'd0) begin
         fails++;
         $display("FAIL async_reset flags=%b frame=%h result=%h want all 0",
                  {start_a, busy_a, rv_a, ovr_a}, frame_a, result_a);
      end
      eoc = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      s0 = start_cnt_a;
      for (int k = 0; k < 7; k++) send(8'h31 + 8'(k));
      repeat (30) @(negedge clk);
      tests++;
      if (start_cnt_a != s0) begin
         fails++;
         $display("FAIL reset_refill starts=%0d want=0", start_cnt_a - s0);
      end
      send(8'h38);
      wait_start_a(got);
      tests++;
      if (!got || frame_a !== 64'h3837363534333231) begin
         fails++;
         $display("FAIL reset_frame got=%h start=%b want=3837363534333231",
                  frame_a, got);
      end
   endtask

   task automatic test_wrap();
      bit got;
      int s0;
      int miss = 0;
      do_reset();
      s0 = start_cnt_a;
      for (int k = 1; k <= 40; k++) begin
         send(8'(k));
         if (k % 8 == 0) begin
            wait_start_a(got);
            if (!got) miss++;
            if (k == 40) begin
               tests++;
               if (frame_a !== 64'h2827262524232221) begin
                  fails++;
                  $display("FAIL wrap_frame5 got=%h want=2827262524232221",
                           frame_a);
               end
            end
            @(negedge clk);
            pulse_done_a(8'(k));
         end
      end
      repeat (4) @(negedge clk);
      tests++;
      if (start_cnt_a - s0 != 5 || miss != 0 || ovr_a !== 1'b0) begin
         fails++;
         $display("FAIL wrap_count starts=%0d timeouts=%0d ovr=%b want 5 0 0",
                  start_cnt_a - s0, miss, ovr_a);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_overrun();
      test_held_eoc();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
